// File: rtl/bram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_ctrl_pkg
// Description : Shared types and constants for the frame-memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_ctrl_pkg;

    localparam int c_NUM_RD = 2;
    localparam int c_DISP   = 0;
    localparam int c_HOST   = 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    typedef logic [c_NUM_RD-1:0] gnt_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter with per-request blocking mask.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import bram_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  gnt_t req,
    input  gnt_t mask,
    output gnt_t gnt
);

    logic r_ptr;
    gnt_t w_elig;

    always_comb begin
        w_elig = req & ~mask;
        gnt    = '0;
        if (!rst) begin
            if (&w_elig) begin
                gnt[r_ptr] = 1'b1;
            end else begin
                gnt = w_elig;
            end
        end
    end

    // A blocked request leaves no grant, so the pointer holds until it wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (|gnt) begin
            r_ptr <= gnt[c_DISP];
        end
    end

endmodule
`default_nettype wire

// File: rtl/bram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bram_ctrl
// Description : Frame-memory BRAM front end: read arbitration, host writes,
//               read/write collision blocking and a hardware clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 8,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       rd_req,
    input  logic [DEPTH-1:0] rd_addr0,
    input  logic [DEPTH-1:0] rd_addr1,
    output logic [1:0]       rd_gnt,
    output logic [1:0]       rd_valid,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wr_req,
    input  logic [DEPTH-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ack,
    input  logic             clr_start,
    output logic             clr_busy,
    output logic             bram_re,
    output logic             bram_we,
    output logic [DEPTH-1:0] bram_addr_rd,
    output logic [DEPTH-1:0] bram_addr_wr,
    output logic [WIDTH-1:0] bram_data_wr,
    input  logic [WIDTH-1:0] bram_data_rd
);

    localparam logic [DEPTH:0] c_LAST = {1'b0, {DEPTH{1'b1}}};
    localparam logic [DEPTH:0] c_ONE  = {{DEPTH{1'b0}}, 1'b1};

    state_t           r_state, w_state_nxt;
    logic [DEPTH:0]   r_cnt, w_cnt_nxt;
    gnt_t             r_valid;
    gnt_t             w_gnt;
    gnt_t             w_mask;
    logic             w_we;
    logic [DEPTH-1:0] w_waddr;
    logic [WIDTH-1:0] w_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_valid <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_gnt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_we        = 1'b0;
        w_waddr     = wr_addr;
        w_wdata     = wr_data;
        wr_ack      = 1'b0;
        clr_busy    = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    w_we   = wr_req;
                    wr_ack = wr_req;
                    if (clr_start) begin
                        w_state_nxt = CLEAR;
                        w_cnt_nxt   = '0;
                    end
                end
                CLEAR: begin
                    // The sweep owns the write port; host writes wait it out.
                    clr_busy = 1'b1;
                    w_we     = 1'b1;
                    w_waddr  = r_cnt[DEPTH-1:0];
                    w_wdata  = CLEAR_VAL;
                    if (r_cnt == c_LAST) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_ONE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // A read of the address being written this cycle retries, returning new data.
    always_comb begin
        w_mask         = '0;
        w_mask[c_DISP] = w_we && (rd_addr0 == w_waddr);
        w_mask[c_HOST] = w_we && (rd_addr1 == w_waddr);
    end

    rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (rd_req),
        .mask (w_mask),
        .gnt  (w_gnt)
    );

    assign rd_gnt       = w_gnt;
    assign rd_valid     = rst ? '0 : r_valid;
    assign rd_data      = bram_data_rd;
    assign bram_re      = |w_gnt;
    assign bram_addr_rd = w_gnt[c_HOST] ? rd_addr1 : rd_addr0;
    assign bram_we      = w_we;
    assign bram_addr_wr = w_waddr;
    assign bram_data_wr = w_wdata;

endmodule
`default_nettype wire

// File: tb/tb_bram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_ctrl
// Description : Self-checking bench for bram_ctrl with a BRAM model and a
//               cycle-level reference model of the controller's rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_ctrl;

    localparam int         SIZE = 256;
    localparam logic [7:0] CV   = 8'h00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] rd_req = '0;
    logic [7:0] rd_addr0 = '0, rd_addr1 = '0;
    logic [1:0] rd_gnt, rd_valid;
    logic [7:0] rd_data;
    logic       wr_req = 1'b0;
    logic [7:0] wr_addr = '0, wr_data = '0;
    logic       wr_ack;
    logic       clr_start = 1'b0;
    logic       clr_busy;
    logic       bram_re, bram_we;
    logic [7:0] bram_addr_rd, bram_addr_wr, bram_data_wr, bram_data_rd;

    int n_vec = 0;
    int n_err = 0;

    bram_ctrl #(.WIDTH(8), .DEPTH(8), .CLEAR_VAL(CV)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .bram_re(bram_re), .bram_we(bram_we),
        .bram_addr_rd(bram_addr_rd), .bram_addr_wr(bram_addr_wr),
        .bram_data_wr(bram_data_wr), .bram_data_rd(bram_data_rd)
    );

    always #5 clk = ~clk;

    logic [7:0] bmem [SIZE];
    logic [7:0] bq;
    always @(posedge clk) begin
        if (bram_we) bmem[bram_addr_wr] <= bram_data_wr;
        if (bram_re) bq <= bmem[bram_addr_rd];
    end
    assign bram_data_rd = bq;

    // Reference model state
    logic [7:0] m_mem [SIZE];
    bit         m_clearing = 1'b0;
    int         m_cpos = 0;
    int         m_prefer = 0;
    logic [1:0] m_pend = '0;
    logic [7:0] m_pend_data = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        logic       ewe;
        logic [7:0] waddr, wdat;
        logic [1:0] elig, eg;
        int         win;
        if (rst) begin
            chk("rst_gnt", rd_gnt, 0);
            chk("rst_valid", rd_valid, 0);
            chk("rst_ack", wr_ack, 0);
            chk("rst_busy", clr_busy, 0);
            chk("rst_re", bram_re, 0);
            chk("rst_we", bram_we, 0);
            m_clearing = 1'b0;
            m_cpos     = 0;
            m_prefer   = 0;
            m_pend     = '0;
        end else begin
            if (m_clearing) begin
                ewe = 1'b1; waddr = 8'(m_cpos); wdat = CV;
            end else begin
                ewe = wr_req; waddr = wr_addr; wdat = wr_data;
            end
            elig[0] = rd_req[0] && !(ewe && rd_addr0 == waddr);
            elig[1] = rd_req[1] && !(ewe && rd_addr1 == waddr);
            if (elig == 2'b11)  win = m_prefer;
            else if (elig[0])   win = 0;
            else if (elig[1])   win = 1;
            else                win = -1;
            eg = (win < 0) ? 2'b00 : ((win == 0) ? 2'b01 : 2'b10);
            chk("m_gnt", rd_gnt, eg);
            chk("m_valid", rd_valid, m_pend);
            if (m_pend != 0) chk("m_data", rd_data, m_pend_data);
            chk("m_ack", wr_ack, !m_clearing && wr_req);
            chk("m_busy", clr_busy, m_clearing);
            chk("m_re", bram_re, win >= 0);
            chk("m_we", bram_we, ewe);
            if (ewe) begin
                chk("m_waddr", bram_addr_wr, waddr);
                chk("m_wdata", bram_data_wr, wdat);
            end
            if (win >= 0) chk("m_raddr", bram_addr_rd, (win == 1) ? rd_addr1 : rd_addr0);
            m_pend = eg;
            if (win >= 0) begin
                m_pend_data = m_mem[(win == 1) ? rd_addr1 : rd_addr0];
                m_prefer    = 1 - win;
            end
            if (ewe) m_mem[waddr] = wdat;
            if (m_clearing) begin
                m_cpos++;
                if (m_cpos == SIZE) begin
                    m_clearing = 1'b0;
                    m_cpos     = 0;
                end
            end else if (clr_start) begin
                m_clearing = 1'b1;
                m_cpos     = 0;
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic do_reset();
        rst = 1'b1; rd_req = '0; wr_req = 1'b0; clr_start = 1'b0;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [7:0] fill_val(int mode, int a);
        if (mode == 0) return (a == 16'h10) ? 8'hA5 : (a == 16'h20) ? 8'h11 : 8'($urandom);
        return 8'(a) | 8'h80;
    endfunction

    task automatic fill(int mode);
        for (int a = 0; a < SIZE; a++) begin
            rd_req = '0; wr_req = 1'b1; wr_addr = 8'(a); wr_data = fill_val(mode, a);
            step();
        end
        wr_req = 1'b0;
    endtask

    function automatic logic [7:0] read_exp(int mode, int a);
        if (mode == 0) return 8'h00;
        return (a < 100) ? 8'h00 : (8'(a) | 8'h80);
    endfunction

    task automatic read_all(int mode);
        for (int a = 0; a <= SIZE; a++) begin
            rd_req   = (a < SIZE) ? 2'b10 : 2'b00;
            rd_addr1 = 8'(a);
            sample();
            if (a > 0) begin
                chk("readall_valid", rd_valid, 2'b10);
                chk("readall_data", rd_data, read_exp(mode, a - 1));
            end
            advance();
        end
        rd_req = '0;
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [7:0] a0, a1;
        logic       wr;
        logic [7:0] waddr, wdata;
        logic [1:0] egnt, evalid;
        logic [7:0] edata;
        logic       eack;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic r, logic [1:0] q, logic [7:0] a0, logic [7:0] a1,
                               logic w, logic [7:0] wa, logic [7:0] wd,
                               logic [1:0] eg, logic [1:0] ev, logic [7:0] ed, logic ea);
        vec_t x;
        x.rst = r; x.req = q; x.a0 = a0; x.a1 = a1; x.wr = w; x.waddr = wa; x.wdata = wd;
        x.egnt = eg; x.evalid = ev; x.edata = ed; x.eack = ea;
        return x;
    endfunction

    int  busy_cnt, ack_busy;
    bit  done;

    initial begin
        tbl.push_back(v(1, 2'b11, 8'h10, 8'h20, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(v(0, 2'b01, 8'h10, 8'h20, 0, 0, 0, 2'b01, 2'b00, 0, 0));
        tbl.push_back(v(0, 2'b00, 8'h10, 8'h20, 0, 0, 0, 2'b00, 2'b01, 8'hA5, 0));
        tbl.push_back(v(1, 2'b11, 8'h10, 8'h20, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(v(0, 2'b11, 8'h10, 8'h20, 0, 0, 0, 2'b01, 2'b00, 0, 0));
        tbl.push_back(v(0, 2'b11, 8'h10, 8'h20, 0, 0, 0, 2'b10, 2'b01, 8'hA5, 0));
        tbl.push_back(v(0, 2'b11, 8'h10, 8'h20, 0, 0, 0, 2'b01, 2'b10, 8'h11, 0));
        tbl.push_back(v(0, 2'b11, 8'h10, 8'h20, 0, 0, 0, 2'b10, 2'b01, 8'hA5, 0));
        tbl.push_back(v(0, 2'b11, 8'h10, 8'h20, 0, 0, 0, 2'b01, 2'b10, 8'h11, 0));
        tbl.push_back(v(0, 2'b11, 8'h10, 8'h20, 0, 0, 0, 2'b10, 2'b01, 8'hA5, 0));
        tbl.push_back(v(0, 2'b00, 8'h10, 8'h20, 0, 0, 0, 2'b00, 2'b10, 8'h11, 0));
        tbl.push_back(v(0, 2'b10, 8'h10, 8'h20, 1, 8'h20, 8'h3C, 2'b00, 2'b00, 0, 1));
        tbl.push_back(v(0, 2'b10, 8'h10, 8'h20, 0, 0, 0, 2'b10, 2'b00, 0, 0));
        tbl.push_back(v(0, 2'b00, 8'h10, 8'h20, 0, 0, 0, 2'b00, 2'b10, 8'h3C, 0));
        tbl.push_back(v(0, 2'b01, 8'h10, 8'h20, 0, 0, 0, 2'b01, 2'b00, 0, 0));
        tbl.push_back(v(1, 2'b11, 8'h10, 8'h20, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(v(0, 2'b11, 8'h10, 8'h20, 0, 0, 0, 2'b01, 2'b00, 0, 0));
        tbl.push_back(v(0, 2'b00, 8'h10, 8'h20, 0, 0, 0, 2'b00, 2'b01, 8'hA5, 0));

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        fill(0);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; rd_req = tbl[i].req; rd_addr0 = tbl[i].a0; rd_addr1 = tbl[i].a1;
            wr_req = tbl[i].wr; wr_addr = tbl[i].waddr; wr_data = tbl[i].wdata; clr_start = 1'b0;
            sample();
            chk($sformatf("tbl%0d_gnt", i), rd_gnt, tbl[i].egnt);
            chk($sformatf("tbl%0d_valid", i), rd_valid, tbl[i].evalid);
            chk($sformatf("tbl%0d_ack", i), wr_ack, tbl[i].eack);
            if (tbl[i].evalid != 0) chk($sformatf("tbl%0d_data", i), rd_data, tbl[i].edata);
            advance();
        end
        rst = 1'b0; rd_req = '0; wr_req = 1'b0;

        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            clr_start = ($urandom_range(0, 149) == 0);
            rd_req    = 2'($urandom_range(0, 3));
            rd_addr0  = 8'($urandom_range(0, 7));
            rd_addr1  = 8'($urandom_range(0, 7));
            wr_req    = 1'($urandom_range(0, 1));
            wr_addr   = 8'($urandom_range(0, 7));
            wr_data   = 8'($urandom);
            step();
        end

        // Full sweep with a stalled host write and an ignored mid-sweep start
        do_reset();
        clr_start = 1'b1; wr_req = 1'b1; wr_addr = 8'h33; wr_data = 8'h00;
        step();
        clr_start = 1'b0;
        busy_cnt = 0; ack_busy = 0;
        for (int i = 0; i < 300; i++) begin
            sample();
            if (clr_busy) begin
                busy_cnt++;
                if (wr_ack) ack_busy++;
            end
            advance();
            clr_start = (i == 99);
        end
        chk("clr_busy_cycles", busy_cnt, 256);
        chk("wr_ack_during_clear", ack_busy, 0);
        wr_req = 1'b0; clr_start = 1'b0;
        read_all(0);

        // Reset at sweep cycle 100 leaves the upper addresses untouched
        do_reset();
        fill(1);
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (100) step();
        rst = 1'b1;
        sample();
        chk("midrst_busy", clr_busy, 0);
        chk("midrst_we", bram_we, 0);
        advance();
        rst = 1'b0;
        sample();
        chk("postrst_busy", clr_busy, 0);
        chk("postrst_we", bram_we, 0);
        advance();
        read_all(1);

        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        sample();
        chk("restart_busy", clr_busy, 1);
        chk("restart_addr", bram_addr_wr, 0);
        advance();
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            sample();
            if (!clr_busy) begin
                done = 1'b1;
                break;
            end
            advance();
        end
        chk("restart_sweep_ends", done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
